// File: rtl/vga_layer_compositor.sv
// Prioritised layer mux with registered rgb, plus collision tracking, game-state FSM and BCD scoring.
// Layer 0 has the highest priority; collisions are resolved once per frame on frame_tick.
module vga_layer_compositor #(
  parameter int                      NUM_LAYERS   = 4,
  parameter int                      COLOR_W      = 12,
  parameter logic [COLOR_W-1:0]      BG_COLOR     = 12'h5CC,
  parameter logic [COLOR_W-1:0]      FLASH_COLOR  = 12'hFFF,
  parameter int                      BIRD_LAYER   = 0,
  parameter logic [NUM_LAYERS-1:0]   HAZARD_MASK  = 4'b0010,
  parameter int                      SCORE_DIGITS = 4,
  parameter int                      FLASH_FRAMES = 32,
  parameter int                      H_LAST       = 799,
  parameter int                      V_LAST       = 524
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            bright,
  input  logic [9:0]                      hCount,
  input  logic [9:0]                      vCount,
  input  logic [NUM_LAYERS-1:0]           layer_hit,
  input  logic [NUM_LAYERS*COLOR_W-1:0]   layer_rgb,
  input  logic                            flap_pulse,
  input  logic                            point_pulse,
  input  logic                            out_of_bounds,
  output logic [COLOR_W-1:0]              rgb,
  output logic [1:0]                      game_state,
  output logic                            alive,
  output logic                            frame_tick,
  output logic [4*SCORE_DIGITS-1:0]       score,
  output logic [4*SCORE_DIGITS-1:0]       high_score
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;

  localparam logic [NUM_LAYERS-1:0] BIRD_BIT = NUM_LAYERS'(1) << BIRD_LAYER;
  localparam logic [NUM_LAYERS-1:0] KILL_MASK = HAZARD_MASK & ~BIRD_BIT;

  state_t                 state, next_state;
  logic                   coll_flag;
  logic                   coll_now;
  logic [7:0]             flash_cnt;
  logic [COLOR_W-1:0]     pix_p0;
  logic [COLOR_W-1:0]     rgb_p1;

  // Saturating BCD ripple increment; all-9s holds.
  function automatic logic [4*SCORE_DIGITS-1:0] bcd_inc(input logic [4*SCORE_DIGITS-1:0] s);
    logic [4*SCORE_DIGITS-1:0] r;
    logic carry;
    logic sat;
    r     = s;
    carry = 1'b1;
    sat   = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (s[4*d +: 4] != 4'd9) sat = 1'b0;
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return sat ? s : r;
  endfunction

  assign coll_now = (bright && layer_hit[BIRD_LAYER] && |(layer_hit & KILL_MASK)) || out_of_bounds;

  // Stage p0: combinational pixel selection from the current inputs and state
  always_comb begin
    pix_p0 = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i]) pix_p0 = layer_rgb[i*COLOR_W +: COLOR_W];
    end
    if (state == DYING && flash_cnt[2]) pix_p0 = FLASH_COLOR;
    if (!bright) pix_p0 = '0;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (flap_pulse) next_state = PLAY;
      PLAY:    if (frame_tick && (coll_flag || coll_now)) next_state = DYING;
      DYING:   if (frame_tick && flash_cnt == 8'd1) next_state = OVER;
      OVER:    if (flap_pulse) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stage p1: registered pixel, state and game bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rgb_p1     <= '0;
      alive      <= 1'b0;
      frame_tick <= 1'b0;
      score      <= '0;
      high_score <= '0;
      coll_flag  <= 1'b0;
      flash_cnt  <= 8'd0;
    end else begin
      state      <= next_state;
      alive      <= (next_state == PLAY);
      rgb_p1     <= pix_p0;
      frame_tick <= (hCount == 10'(H_LAST)) && (vCount == 10'(V_LAST));
      case (state)
        IDLE: if (flap_pulse) score <= '0;
        PLAY: begin
          if (point_pulse) score <= bcd_inc(score);
          if (frame_tick)    coll_flag <= 1'b0;
          else if (coll_now) coll_flag <= 1'b1;
          if (next_state == DYING) flash_cnt <= 8'(FLASH_FRAMES);
        end
        DYING: if (frame_tick) begin
          flash_cnt <= flash_cnt - 8'd1;
          if (next_state == OVER && score > high_score) high_score <= score;
        end
        default: ;
      endcase
    end
  end

  assign rgb        = rgb_p1;
  assign game_state = state;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor: pixel priority, collision/FSM flow, scoring and flash.
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
module tb_vga_layer_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic        bright;
  logic [9:0]  hCount, vCount;
  logic [3:0]  layer_hit;
  logic [47:0] layer_rgb;
  logic        flap_pulse, point_pulse, out_of_bounds;
  logic [11:0] rgb;
  logic [1:0]  game_state;
  logic        alive, frame_tick;
  logic [15:0] score, high_score;

  int checks = 0;
  int failures = 0;

  vga_layer_compositor dut (
    .clk(clk), .reset(reset), .bright(bright), .hCount(hCount), .vCount(vCount),
    .layer_hit(layer_hit), .layer_rgb(layer_rgb), .flap_pulse(flap_pulse),
    .point_pulse(point_pulse), .out_of_bounds(out_of_bounds), .rgb(rgb),
    .game_state(game_state), .alive(alive), .frame_tick(frame_tick),
    .score(score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame boundary: frame_tick rises after the first edge, is consumed on the second.
  task automatic frame();
    hCount = 10'd799; vCount = 10'd524;
    tick();
    hCount = 10'd0; vCount = 10'd0;
    tick();
  endtask

  task automatic flap();
    flap_pulse = 1'b1;
    tick();
    flap_pulse = 1'b0;
  endtask

  task automatic points(input int n);
    point_pulse = 1'b1;
    repeat (n) tick();
    point_pulse = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; bright = 1'b0; hCount = 0; vCount = 0; layer_hit = 0;
    layer_rgb = {12'hABC, 12'h0F0, 12'hF00, 12'h00F};
    flap_pulse = 0; point_pulse = 0; out_of_bounds = 0;
    repeat (2) tick();
    checks++; if (rgb !== 12'h000 || game_state !== 2'd0 || alive !== 1'b0 || frame_tick !== 1'b0)
      begin failures++; $display("FAIL por_state rgb=%h st=%0d alive=%b ft=%b exp 000/0/0/0", rgb, game_state, alive, frame_tick); end
    checks++; if (score !== 16'h0 || high_score !== 16'h0)
      begin failures++; $display("FAIL por_score score=%h hs=%h exp 0000/0000", score, high_score); end
    reset = 1'b1;
    tick();
    // Build up some state mid-frame, then yank reset between edges.
    hCount = 10'd300; vCount = 10'd200;
    flap();
    points(3);
    bright = 1'b1; layer_hit = 4'b0001;
    tick();
    checks++; if (rgb !== 12'h00F || score !== 16'h0003 || game_state !== 2'd1)
      begin failures++; $display("FAIL pre_reset rgb=%h score=%h st=%0d exp 00F/0003/1", rgb, score, game_state); end
    #2 reset = 1'b0;
    #1;
    checks++; if (rgb !== 12'h000 || game_state !== 2'd0 || alive !== 1'b0)
      begin failures++; $display("FAIL async_reset rgb=%h st=%0d alive=%b exp 000/0/0", rgb, game_state, alive); end
    checks++; if (score !== 16'h0 || high_score !== 16'h0)
      begin failures++; $display("FAIL async_reset_score score=%h hs=%h exp 0/0", score, high_score); end
    bright = 1'b0; layer_hit = 4'b0000;
    #1 reset = 1'b1;
    hCount = 0; vCount = 0;
    tick();
    checks++; if (rgb !== 12'h000 || game_state !== 2'd0)
      begin failures++; $display("FAIL post_release rgb=%h st=%0d exp 000/0", rgb, game_state); end
  endtask

  task automatic test_pixel_priority();
    bright = 1'b1;
    layer_hit = 4'b0110; tick();
    checks++; if (rgb !== 12'hF00) begin failures++; $display("FAIL prio_0110 rgb=%h exp F00", rgb); end
    layer_hit = 4'b0000; tick();
    checks++; if (rgb !== 12'h5CC) begin failures++; $display("FAIL prio_bg rgb=%h exp 5CC", rgb); end
    layer_hit = 4'b1000; tick();
    checks++; if (rgb !== 12'hABC) begin failures++; $display("FAIL prio_1000 rgb=%h exp ABC", rgb); end
    layer_hit = 4'b1111; tick();
    checks++; if (rgb !== 12'h00F) begin failures++; $display("FAIL prio_1111 rgb=%h exp 00F", rgb); end
    layer_hit = 4'b1100; tick();
    checks++; if (rgb !== 12'h0F0) begin failures++; $display("FAIL prio_1100 rgb=%h exp 0F0", rgb); end
    bright = 1'b0; layer_hit = 4'b1111; tick();
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL prio_blank rgb=%h exp 000", rgb); end
    layer_hit = 4'b0000;
  endtask

  task automatic test_collision_dying();
    // Bird+pipe overlap in IDLE must not matter.
    bright = 1'b1; layer_hit = 4'b0011; tick(); layer_hit = 0;
    frame();
    checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL idle_no_coll st=%0d exp 0", game_state); end
    flap();
    checks++; if (game_state !== 2'd1 || alive !== 1'b1)
      begin failures++; $display("FAIL flap_play st=%0d alive=%b exp 1/1", game_state, alive); end
    // Bird overlapping a non-hazard layer is harmless.
    layer_hit = 4'b0101; tick(); layer_hit = 0;
    frame();
    checks++; if (game_state !== 2'd1) begin failures++; $display("FAIL nonhazard st=%0d exp 1", game_state); end
    hCount = 10'd210; vCount = 10'd100; layer_hit = 4'b0011; tick();
    layer_hit = 0; hCount = 0; vCount = 0;
    repeat (3) tick();
    checks++; if (game_state !== 2'd1) begin failures++; $display("FAIL coll_deferred st=%0d exp 1", game_state); end
    hCount = 10'd799; vCount = 10'd524; tick();
    checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL frame_tick ft=%b exp 1", frame_tick); end
    hCount = 0; vCount = 0; tick();
    checks++; if (frame_tick !== 1'b0 || game_state !== 2'd2 || alive !== 1'b0)
      begin failures++; $display("FAIL enter_dying ft=%b st=%0d alive=%b exp 0/2/0", frame_tick, game_state, alive); end
    // flash_cnt=32: bit2 clear, normal layer colour.
    bright = 1'b1; layer_hit = 4'b0001; tick();
    checks++; if (rgb !== 12'h00F) begin failures++; $display("FAIL dying_noflash rgb=%h exp 00F", rgb); end
    frame();
    // flash_cnt=31: bit2 set, flash wins over layers.
    layer_hit = 4'b0110; tick();
    checks++; if (rgb !== 12'hFFF) begin failures++; $display("FAIL dying_flash rgb=%h exp FFF", rgb); end
    bright = 1'b0; tick();
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL dying_blank rgb=%h exp 000", rgb); end
    layer_hit = 0;
    flap(); tick();
    checks++; if (game_state !== 2'd2) begin failures++; $display("FAIL dying_flap st=%0d exp 2", game_state); end
    repeat (30) frame();
    checks++; if (game_state !== 2'd2) begin failures++; $display("FAIL dying_31 st=%0d exp 2", game_state); end
    frame();
    checks++; if (game_state !== 2'd3 || high_score !== 16'h0)
      begin failures++; $display("FAIL over_32 st=%0d hs=%h exp 3/0000", game_state, high_score); end
  endtask

  task automatic test_score_high();
    flap();
    checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL over_to_idle st=%0d exp 0", game_state); end
    points(2);
    checks++; if (score !== 16'h0) begin failures++; $display("FAIL idle_points score=%h exp 0000", score); end
    flap();
    points(12);
    checks++; if (score !== 16'h0012) begin failures++; $display("FAIL score12 score=%h exp 0012", score); end
    out_of_bounds = 1'b1; tick(); out_of_bounds = 1'b0;
    frame();
    checks++; if (game_state !== 2'd2) begin failures++; $display("FAIL oob_dying st=%0d exp 2", game_state); end
    points(3);
    checks++; if (score !== 16'h0012) begin failures++; $display("FAIL dying_points score=%h exp 0012", score); end
    repeat (32) frame();
    checks++; if (game_state !== 2'd3 || high_score !== 16'h0012)
      begin failures++; $display("FAIL hs12 st=%0d hs=%h exp 3/0012", game_state, high_score); end
    flap();
    checks++; if (score !== 16'h0012) begin failures++; $display("FAIL idle_hold score=%h exp 0012", score); end
    flap();
    checks++; if (score !== 16'h0 || game_state !== 2'd1)
      begin failures++; $display("FAIL replay_clear score=%h st=%0d exp 0000/1", score, game_state); end
    points(4);
    // Collision and point on the very cycle frame_tick is high: both take effect.
    hCount = 10'd799; vCount = 10'd524; tick();
    hCount = 0; vCount = 0; out_of_bounds = 1'b1; point_pulse = 1'b1; tick();
    out_of_bounds = 1'b0; point_pulse = 1'b0;
    checks++; if (game_state !== 2'd2 || score !== 16'h0005)
      begin failures++; $display("FAIL same_cycle st=%0d score=%h exp 2/0005", game_state, score); end
    repeat (32) frame();
    checks++; if (game_state !== 2'd3 || high_score !== 16'h0012 || score !== 16'h0005)
      begin failures++; $display("FAIL hs_keep st=%0d hs=%h score=%h exp 3/0012/0005", game_state, high_score, score); end
  endtask

  task automatic test_saturation();
    flap(); flap();
    points(9998);
    checks++; if (score !== 16'h9998) begin failures++; $display("FAIL score9998 score=%h exp 9998", score); end
    points(1);
    checks++; if (score !== 16'h9999) begin failures++; $display("FAIL score9999 score=%h exp 9999", score); end
    points(1);
    checks++; if (score !== 16'h9999) begin failures++; $display("FAIL score_sat score=%h exp 9999", score); end
    out_of_bounds = 1'b1; tick(); out_of_bounds = 1'b0;
    repeat (33) frame();
    checks++; if (game_state !== 2'd3 || high_score !== 16'h9999)
      begin failures++; $display("FAIL hs9999 st=%0d hs=%h exp 3/9999", game_state, high_score); end
  endtask

  initial begin
    test_reset();
    test_pixel_priority();
    test_collision_dying();
    test_score_high();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
